// File: rtl/pla_alu_sliced.sv
// -----------------------------------------------------------------------------
// pla_alu_sliced
//
// Bit-serial (slice-serial) ALU. A request is accepted in IDLE. The operands
// are then processed SLICE bits per clock in RUN, least significant slice
// first, with a carry register between slices. The result is presented in
// HOLD until the consumer takes it.
//
// Modes
//   mode = 0 (logic): y[i] = fn[{a[i], b[i]}], cout = 0
//   mode = 1 (arith): y = a + (fn[0] ? ~b : b) + cin, cout = carry out of MSB
//
// Optional feature (compile-time macro PLA_ALU_BYPASS_EN)
//   When defined, logic-mode requests finish in a single RUN cycle because
//   there is no carry chain to serialise. Arithmetic mode is unchanged.
//   When undefined, both modes take WIDTH/SLICE RUN cycles.
//
// Handshake (both ports): a transfer happens on a rising clk edge where valid
// and ready are both high. The producer holds valid and its payload steady
// until that edge. in_ready is high only in IDLE. out_valid is high only in
// HOLD. After the output transfer the block returns to IDLE, so a new request
// can be accepted one cycle later, never in the same cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   request can be accepted (IDLE)
//   a, b       operands, WIDTH bits
//   fn         logic truth table / fn[0] = subtract select
//   mode       0 = logic, 1 = arithmetic
//   cin        carry in (arithmetic only)
//   out_valid  result present (HOLD)
//   out_ready  consumer accepts result
//   y          result
//   cout       carry out of the MSB (0 in logic mode)
//   zero       y == 0
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 HOLD)
// -----------------------------------------------------------------------------
module pla_alu_sliced #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fn,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       fn_r;
    logic             mode_r;

    // Per-bit table lookup across the whole word.
    function automatic logic [WIDTH-1:0] pla_eval(input logic [3:0]       f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = f[{x[i], z[i]}];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] logic_full;
    logic [WIDTH-1:0] b_eff;
    logic [SLICE:0]   slice_sum;
    logic [SLICE-1:0] slice_res;
    logic [WIDTH-1:0] y_shift;
    logic [WIDTH-1:0] y_next;
    logic             last;
    logic             finish_now;

    // a_r and b_r are shifted right by SLICE every RUN cycle, so the slice
    // being worked on is always at bit 0. Each finished slice enters y at the
    // top and moves down. After NS cycles the first slice sits at bit 0.
    always_comb begin
        logic_full = pla_eval(fn_r, a_r, b_r);
        b_eff      = fn_r[0] ? ~b_r : b_r;
        slice_sum  = {1'b0, a_r[SLICE-1:0]} + {1'b0, b_eff[SLICE-1:0]}
                   + (SLICE+1)'(carry);
        slice_res  = mode_r ? slice_sum[SLICE-1:0] : logic_full[SLICE-1:0];
        y_shift    = (y >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
        last       = (cnt == CW'(NS - 1));
`ifdef PLA_ALU_BYPASS_EN
        // No carry chain in logic mode. a_r is still unshifted in the first
        // RUN cycle, so the whole word can be produced at once.
        finish_now = last | ~mode_r;
        y_next     = mode_r ? y_shift : logic_full;
`else
        finish_now = last;
        y_next     = y_shift;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            fn_r      <= 4'd0;
            mode_r    <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        fn_r   <= fn;
                        mode_r <= mode;
                        // The carry register seeds slice 0. Logic mode ignores it.
                        carry  <= cin & mode;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_r   <= a_r >> SLICE;
                    b_r   <= b_r >> SLICE;
                    carry <= slice_sum[SLICE];
                    y     <= y_next;
                    cnt   <= cnt + CW'(1);
                    if (finish_now) begin
                        cnt       <= '0;
                        cout      <= mode_r & slice_sum[SLICE];
                        zero      <= (y_next == '0);
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pla_alu_sliced.sv
// -----------------------------------------------------------------------------
// tb_pla_alu_sliced
//
// Directed bench for pla_alu_sliced with WIDTH=16 and SLICE=4. Every expected
// result was worked out by hand and is stored in the vectors. An expected-y
// queue pairs each request with its result. Logic-mode latency follows
// PLA_ALU_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_pla_alu_sliced;

  localparam int W = 16;

`ifdef PLA_ALU_BYPASS_EN
  localparam int LOGIC_LAT = 1;
`else
  localparam int LOGIC_LAT = 4;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   fn;
  logic         mode;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         cout;
  logic         zero;
  logic [1:0]   state_dbg;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  pla_alu_sliced #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fn        (fn),
    .mode      (mode),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .zero      (zero),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and waits, with a bound, for out_valid. It then checks
  // the latency and the result. If out_ready is high it also lets the output
  // handshake complete, so the DUT is back in IDLE on return.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [3:0] tfn, input logic tmode, input logic tcin,
                        input int exp_lat, input logic [W-1:0] ey,
                        input logic ecout, input logic ezero);
    int lat;
    logic [W-1:0] qy;
    exp_q.push_back(ey);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta; b = tb; fn = tfn; mode = tmode; cin = tcin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the inputs after the accept. The latched copy must be used.
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    fn = 4'($urandom_range(0, 15));
    mode = ~tmode;
    cin = ~tcin;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    qy = (exp_q.size() > 0) ? exp_q.pop_front() : ~ey;
    check({tag, " y"}, 32'(y), 32'(qy));
    check({tag, " cout"}, 32'(cout), 32'(ecout));
    check({tag, " zero"}, 32'(zero), 32'(ezero));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int seen;
    logic [W-1:0] held_y;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0; b = '0; fn = 4'd0; mode = 1'b0; cin = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset y", 32'(y), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    check("post-reset state", 32'(state_dbg), 32'd0);

    // arithmetic vectors
    run_op("add wrap", 16'hFFFF, 16'h0001, 4'h0, 1'b1, 1'b0, 4, 16'h0000, 1'b1, 1'b1);
    run_op("sub cin", 16'h1234, 16'h0234, 4'h1, 1'b1, 1'b1, 4, 16'h1000, 1'b1, 1'b0);
    run_op("add msb", 16'h7FFF, 16'h0001, 4'h0, 1'b1, 1'b0, 4, 16'h8000, 1'b0, 1'b0);
    run_op("sub borrow", 16'h0000, 16'h0001, 4'h1, 1'b1, 1'b1, 4, 16'hFFFF, 1'b0, 1'b0);
    run_op("cin chain", 16'h0FFF, 16'h0000, 4'h0, 1'b1, 1'b1, 4, 16'h1000, 1'b0, 1'b0);
    run_op("sub small", 16'h0005, 16'h0003, 4'hF, 1'b1, 1'b1, 4, 16'h0002, 1'b1, 1'b0);

    // logic vectors
    run_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b0, 1'b0, LOGIC_LAT, 16'h0FF0, 1'b0, 1'b0);
    run_op("and", 16'hF0F0, 16'hFF00, 4'b1000, 1'b0, 1'b1, LOGIC_LAT, 16'hF000, 1'b0, 1'b0);
    run_op("or", 16'hF0F0, 16'hFF00, 4'b1110, 1'b0, 1'b0, LOGIC_LAT, 16'hFFF0, 1'b0, 1'b0);
    run_op("not a", 16'hF0F0, 16'h1234, 4'b0011, 1'b0, 1'b0, LOGIC_LAT, 16'h0F0F, 1'b0, 1'b0);
    run_op("const0", 16'hA5A5, 16'h5A5A, 4'b0000, 1'b0, 1'b1, LOGIC_LAT, 16'h0000, 1'b0, 1'b1);

    // Back-pressure: the result stays put for 5 cycles. A request waiting
    // during the release edge is not taken until the following cycle.
    out_ready = 1'b0;
    run_op("stall", 16'h1234, 16'h0234, 4'h1, 1'b1, 1'b1, 4, 16'h1000, 1'b1, 1'b0);
    held_y = 16'h1000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall y", 32'(y), 32'(held_y));
      check("stall cout", 32'(cout), 32'd1);
      check("stall zero", 32'(zero), 32'd0);
      check("stall in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h0003; b = 16'h0004; fn = 4'h0; mode = 1'b1; cin = 1'b0;
    @(posedge clk);
    #1;
    check("release state idle", 32'(state_dbg), 32'd0);
    check("release in_ready", 32'(in_ready), 32'd1);
    check("release out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("late accept state", 32'(state_dbg), 32'd1);
    seen = 0;
    while (!out_valid && seen < 50) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("late accept latency", 32'(seen), 32'd4);
    check("late accept y", 32'(y), 32'h0007);
    @(posedge clk);
    #1;

    // Reset in the 2nd RUN cycle. The partial result must vanish and no
    // result may appear afterwards.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h1111; b = 16'h1111; fn = 4'h0; mode = 1'b1; cin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid-run state", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort y", 32'(y), 32'd0);
    check("abort state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort no result", 32'(seen), 32'd0);
    run_op("after abort", 16'h0003, 16'h0004, 4'h0, 1'b1, 1'b0, 4, 16'h0007, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pla_alu_sliced.md
PLA_ALU_SLICED -- requirements
Module: pla_alu_sliced

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4: bits processed per cycle; WIDTH is a multiple of SLICE.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operation request present.
REQ-006 SHALL have port in_ready, output, 1: block can accept a request.
REQ-007 SHALL have ports a and b, input, WIDTH each: operands.
REQ-008 SHALL have port fn, input, 4: logic truth table (logic mode); fn[0] = subtract select (arith mode).
REQ-009 SHALL have port mode, input, 1: 0 = logic, 1 = arithmetic.
REQ-010 SHALL have port cin, input, 1: carry in (arith mode only).
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have ports y, output, WIDTH; cout, output, 1; zero, output, 1: result, carry out, y == 0.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> HOLD -> IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; accept when in_valid & in_ready; latch a, b, fn, mode, cin on accept; ignore later input changes.
REQ-016 SHALL in RUN process one SLICE per cycle, LSB slice first, slice counter 0..WIDTH/SLICE-1, registered carry between slices.
REQ-017 SHALL compute logic mode per bit: y[i] = fn[{a[i],b[i]}] (index 2*a+b); cout = 0.
REQ-018 SHALL compute arith mode: y = a + (fn[0] ? ~b : b) + cin, modulo 2^WIDTH; cout = carry out of MSB.
REQ-019 SHALL enter HOLD after the last slice; out_valid asserts exactly WIDTH/SLICE cycles after the accept edge.
REQ-020 SHALL hold y, cout, zero, out_valid stable in HOLD while out_ready = 0.
REQ-021 SHALL return to IDLE on out_valid & out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-022 SHALL, when SLICE == WIDTH, spend exactly one RUN cycle.
REQ-023 SHALL keep y, cout, zero unchanged outside HOLD except while being built in RUN; they are valid only with out_valid.

Reset
REQ-024 SHALL on rst asynchronously force IDLE, slice counter 0, carry 0, y = 0, cout = 0, zero = 0, out_valid = 0; in_ready = 1 after release.
REQ-025 SHALL discard any in-flight operation on rst mid-RUN or mid-HOLD; no result is produced.

Configuration
REQ-026 SHALL, with PLA_ALU_BYPASS_EN defined, complete logic-mode requests in a single RUN cycle (all slices at once), arith mode unchanged.
REQ-027 SHALL, without PLA_ALU_BYPASS_EN, use WIDTH/SLICE RUN cycles for both modes.

Verification (WIDTH=16, SLICE=4, out_ready=1 unless stated)
REQ-028 SHALL cover: mode=1, fn=0, a=0xFFFF, b=0x0001, cin=0 -> y=0x0000, cout=1, zero=1, out_valid 4 cycles after accept.
REQ-029 SHALL cover: mode=1, fn[0]=1, a=0x1234, b=0x0234, cin=1 -> y=0x1000, cout=1, zero=0.
REQ-030 SHALL cover: mode=0, fn=4'b0110, a=0xF0F0, b=0xFF00 -> y=0x0FF0, cout=0; 1-cycle latency with PLA_ALU_BYPASS_EN, 4 without.
REQ-031 SHALL cover: out_ready=0 for 5 cycles after out_valid -> y, flags stable, in_ready=0 throughout; accept on 6th cycle, in_ready=1 next cycle.
REQ-032 SHALL cover: rst pulsed in 2nd RUN cycle -> out_valid=0, y=0 immediately; in_ready=1 after release; next request (0x0003+0x0004) -> y=0x0007.
